// File: rtl/big_core_f2c_port_arb.sv
// big_core_f2c_port_arb
//   Arbiter/sequencer for the shared port B of the core memories.
//   Fabric (F2C) requests are queued in a small FIFO; local debug/DMA
//   requests arrive over valid/ready. One request is granted per cycle,
//   round-robin between the two sources, and issued as a single port-B
//   read/write command. Port-B read data (1-cycle latency) is routed back
//   to the requester as a registered 1-cycle response pulse.
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   FabReq*                   fabric request (queued), FabReqReady = !full
//   LocReq*                   local request, LocReqReady = granted this cycle
//   PortB*                    port-B command (combinational from grant)
//   PortBRdData               port-B read data, valid the cycle after PortBRdEn
//   FabRsp*, LocRsp*          registered read responses, never backpressured

package big_core_tile_pkg;
  typedef enum logic [1:0] {
    WR     = 2'b00,
    RD     = 2'b01,
    RD_RSP = 2'b10,
    IDLE   = 2'b11
  } t_tile_opcode;
endpackage

module big_core_f2c_port_arb
  import big_core_tile_pkg::*;
#(
  parameter int unsigned FAB_FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W         = 32,  // must be >= 24
  parameter int unsigned DATA_W         = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              FabReqValid,
  output logic              FabReqReady,
  input  t_tile_opcode      FabReqOpcode,
  input  logic [ADDR_W-1:0] FabReqAddress,
  input  logic [DATA_W-1:0] FabReqData,
  input  logic [7:0]        FabReqRequestorId,
  input  logic              LocReqValid,
  output logic              LocReqReady,
  input  logic              LocReqWrEn,
  input  logic [ADDR_W-1:0] LocReqAddress,
  input  logic [DATA_W-1:0] LocReqData,
  output logic [ADDR_W-1:0] PortBAddress,
  output logic [DATA_W-1:0] PortBData,
  output logic              PortBWrEn,
  output logic              PortBRdEn,
  input  logic [DATA_W-1:0] PortBRdData,
  output logic              FabRspValid,
  output logic [31:0]       FabRspAddress,
  output logic [DATA_W-1:0] FabRspData,
  output logic              LocRspValid,
  output logic [DATA_W-1:0] LocRspData
);

  localparam int unsigned PTR_W = $clog2(FAB_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Fabric request queue
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  t_tile_opcode      fifo_op_q   [FAB_FIFO_DEPTH];
  t_tile_opcode      fifo_op_d   [FAB_FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [FAB_FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FAB_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FAB_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FAB_FIFO_DEPTH];
  logic [7:0]        fifo_id_q   [FAB_FIFO_DEPTH];
  logic [7:0]        fifo_id_d   [FAB_FIFO_DEPTH];

  // Round-robin: 1 = local has priority on contention
  logic loc_pri_q, loc_pri_d;

  // Read tag for the cycle the port returns data
  logic        trk_vld_q, trk_vld_d;
  logic        trk_loc_q, trk_loc_d;
  logic [7:0]  trk_id_q, trk_id_d;
  logic [23:0] trk_addr_q, trk_addr_d;

  // Response registers
  logic              fab_rsp_vld_q, fab_rsp_vld_d;
  logic [31:0]       fab_rsp_addr_q, fab_rsp_addr_d;
  logic [DATA_W-1:0] fab_rsp_data_q, fab_rsp_data_d;
  logic              loc_rsp_vld_q, loc_rsp_vld_d;
  logic [DATA_W-1:0] loc_rsp_data_q, loc_rsp_data_d;

  logic              fifo_empty, fifo_full, push;
  logic              cand_f, cand_l, grant_f, grant_l;
  logic [PTR_W-1:0]  head_idx, tail_idx;
  t_tile_opcode      head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [7:0]        head_id;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_data;
  logic              port_wr, port_rd;

  always_comb begin
    head_idx   = rd_ptr_q[PTR_W-1:0];
    tail_idx   = wr_ptr_q[PTR_W-1:0];
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Full blocks a push even when the head is popped the same cycle.
    push       = FabReqValid && !fifo_full;

    head_op   = fifo_op_q[head_idx];
    head_addr = fifo_addr_q[head_idx];
    head_data = fifo_data_q[head_idx];
    head_id   = fifo_id_q[head_idx];

    // Reset gates the candidates so port B stays quiet while Rst is high,
    // even if a local requester keeps LocReqValid asserted.
    cand_f  = !fifo_empty && !Rst;
    cand_l  = LocReqValid && !Rst;
    grant_f = cand_f && (!cand_l || !loc_pri_q);
    grant_l = cand_l && !grant_f;

    loc_pri_d = loc_pri_q;
    if (grant_f)      loc_pri_d = 1'b1;
    else if (grant_l) loc_pri_d = 1'b0;

    wr_ptr_d    = push    ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = grant_f ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fifo_op_d   = fifo_op_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    if (push) begin
      fifo_op_d[tail_idx]   = FabReqOpcode;
      fifo_addr_d[tail_idx] = FabReqAddress;
      fifo_data_d[tail_idx] = FabReqData;
      fifo_id_d[tail_idx]   = FabReqRequestorId;
    end

    // Address/data are driven only alongside a strobe; an unsupported
    // fabric opcode consumes its grant slot with an all-zero command.
    port_addr = '0;
    port_data = '0;
    port_wr   = 1'b0;
    port_rd   = 1'b0;
    if (grant_f) begin
      if (head_op == WR || head_op == RD) begin
        port_addr = head_addr;
        port_data = head_data;
        port_wr   = (head_op == WR);
        port_rd   = (head_op == RD);
      end
    end else if (grant_l) begin
      port_addr = LocReqAddress;
      port_data = LocReqData;
      port_wr   = LocReqWrEn;
      port_rd   = !LocReqWrEn;
    end

    trk_vld_d  = port_rd;
    trk_loc_d  = trk_loc_q;
    trk_id_d   = trk_id_q;
    trk_addr_d = trk_addr_q;
    if (port_rd) begin
      trk_loc_d  = grant_l;
      trk_id_d   = grant_l ? 8'h00 : head_id;
      trk_addr_d = grant_l ? LocReqAddress[23:0] : head_addr[23:0];
    end

    fab_rsp_vld_d  = trk_vld_q && !trk_loc_q;
    loc_rsp_vld_d  = trk_vld_q && trk_loc_q;
    fab_rsp_addr_d = fab_rsp_addr_q;
    fab_rsp_data_d = fab_rsp_data_q;
    loc_rsp_data_d = loc_rsp_data_q;
    if (fab_rsp_vld_d) begin
      fab_rsp_addr_d = {trk_id_q, trk_addr_q};
      fab_rsp_data_d = PortBRdData;
    end
    if (loc_rsp_vld_d) loc_rsp_data_d = PortBRdData;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FAB_FIFO_DEPTH; i++) begin
        fifo_op_q[i]   <= WR;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
      loc_pri_q      <= 1'b0;
      trk_vld_q      <= 1'b0;
      trk_loc_q      <= 1'b0;
      trk_id_q       <= '0;
      trk_addr_q     <= '0;
      fab_rsp_vld_q  <= 1'b0;
      fab_rsp_addr_q <= '0;
      fab_rsp_data_q <= '0;
      loc_rsp_vld_q  <= 1'b0;
      loc_rsp_data_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_op_q      <= fifo_op_d;
      fifo_addr_q    <= fifo_addr_d;
      fifo_data_q    <= fifo_data_d;
      fifo_id_q      <= fifo_id_d;
      loc_pri_q      <= loc_pri_d;
      trk_vld_q      <= trk_vld_d;
      trk_loc_q      <= trk_loc_d;
      trk_id_q       <= trk_id_d;
      trk_addr_q     <= trk_addr_d;
      fab_rsp_vld_q  <= fab_rsp_vld_d;
      fab_rsp_addr_q <= fab_rsp_addr_d;
      fab_rsp_data_q <= fab_rsp_data_d;
      loc_rsp_vld_q  <= loc_rsp_vld_d;
      loc_rsp_data_q <= loc_rsp_data_d;
    end
  end

  assign FabReqReady   = !fifo_full;
  assign LocReqReady   = grant_l;
  assign PortBAddress  = port_addr;
  assign PortBData     = port_data;
  assign PortBWrEn     = port_wr;
  assign PortBRdEn     = port_rd;
  assign FabRspValid   = fab_rsp_vld_q;
  assign FabRspAddress = fab_rsp_addr_q;
  assign FabRspData    = fab_rsp_data_q;
  assign LocRspValid   = loc_rsp_vld_q;
  assign LocRspData    = loc_rsp_data_q;

endmodule

// File: tb/tb_big_core_f2c_port_arb.sv
// Directed testbench for big_core_f2c_port_arb.
module tb_big_core_f2c_port_arb;
  import big_core_tile_pkg::*;

  logic         clk = 1'b0;
  logic         Rst;
  logic         FabReqValid;
  logic         FabReqReady;
  t_tile_opcode FabReqOpcode;
  logic [31:0]  FabReqAddress;
  logic [31:0]  FabReqData;
  logic [7:0]   FabReqRequestorId;
  logic         LocReqValid;
  logic         LocReqReady;
  logic         LocReqWrEn;
  logic [31:0]  LocReqAddress;
  logic [31:0]  LocReqData;
  logic [31:0]  PortBAddress;
  logic [31:0]  PortBData;
  logic         PortBWrEn;
  logic         PortBRdEn;
  logic [31:0]  PortBRdData = '0;
  logic         FabRspValid;
  logic [31:0]  FabRspAddress;
  logic [31:0]  FabRspData;
  logic         LocRspValid;
  logic [31:0]  LocRspData;

  int n_checks = 0;
  int n_errors = 0;
  int fab_rsp_seen = 0;
  int loc_rsp_seen = 0;

  big_core_f2c_port_arb #(
    .FAB_FIFO_DEPTH(4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .Clk(clk), .Rst(Rst),
    .FabReqValid(FabReqValid), .FabReqReady(FabReqReady),
    .FabReqOpcode(FabReqOpcode), .FabReqAddress(FabReqAddress),
    .FabReqData(FabReqData), .FabReqRequestorId(FabReqRequestorId),
    .LocReqValid(LocReqValid), .LocReqReady(LocReqReady),
    .LocReqWrEn(LocReqWrEn), .LocReqAddress(LocReqAddress), .LocReqData(LocReqData),
    .PortBAddress(PortBAddress), .PortBData(PortBData),
    .PortBWrEn(PortBWrEn), .PortBRdEn(PortBRdEn), .PortBRdData(PortBRdData),
    .FabRspValid(FabRspValid), .FabRspAddress(FabRspAddress), .FabRspData(FabRspData),
    .LocRspValid(LocRspValid), .LocRspData(LocRspData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h0001_0010) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Port-B memory model: 1-cycle read latency.
  always @(posedge clk) if (PortBRdEn) PortBRdData <= mem_val(PortBAddress);

  always @(negedge clk) begin
    if (FabRspValid) fab_rsp_seen++;
    if (LocRspValid) loc_rsp_seen++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check the combinational port-B command at negedge.
  task automatic cyc(input string tag,
                     input logic fv, input t_tile_opcode fop, input logic [31:0] fa,
                     input logic [31:0] fd, input logic [7:0] fid,
                     input logic lv, input logic lwe, input logic [31:0] la, input logic [31:0] ld,
                     input logic e_frdy, input logic e_lrdy, input logic e_wr, input logic e_rd,
                     input logic [31:0] e_addr, input logic [31:0] e_data);
    @(posedge clk); #1;
    FabReqValid = fv; FabReqOpcode = fop; FabReqAddress = fa; FabReqData = fd;
    FabReqRequestorId = fid;
    LocReqValid = lv; LocReqWrEn = lwe; LocReqAddress = la; LocReqData = ld;
    @(negedge clk);
    check_eq({tag, ".frdy"}, 64'(FabReqReady), 64'(e_frdy));
    check_eq({tag, ".lrdy"}, 64'(LocReqReady), 64'(e_lrdy));
    check_eq({tag, ".wren"}, 64'(PortBWrEn), 64'(e_wr));
    check_eq({tag, ".rden"}, 64'(PortBRdEn), 64'(e_rd));
    check_eq({tag, ".addr"}, 64'(PortBAddress), 64'(e_addr));
    check_eq({tag, ".data"}, 64'(PortBData), 64'(e_data));
  endtask

  task automatic check_rsp(input string tag, input logic e_fv, input logic [31:0] e_fa,
                           input logic [31:0] e_fd, input logic e_lv, input logic [31:0] e_ld);
    check_eq({tag, ".fvld"}, 64'(FabRspValid), 64'(e_fv));
    check_eq({tag, ".lvld"}, 64'(LocRspValid), 64'(e_lv));
    if (e_fv) begin
      check_eq({tag, ".faddr"}, 64'(FabRspAddress), 64'(e_fa));
      check_eq({tag, ".fdata"}, 64'(FabRspData), 64'(e_fd));
    end
    if (e_lv) check_eq({tag, ".ldata"}, 64'(LocRspData), 64'(e_ld));
  endtask

  task automatic idle(input string tag, input logic e_frdy);
    cyc(tag, 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        e_frdy, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Contention: grant kind per cycle (0 none, 1 fabric, 2 local) and entry index.
  int con_kind [10] = '{0, 1, 2, 1, 2, 1, 2, 1, 0, 0};
  int con_idx  [10] = '{0, 0, 0, 1, 1, 2, 2, 3, 0, 0};
  // Full-queue run with a local writer hogging alternate slots.
  int full_kind [13] = '{2, 1, 2, 1, 2, 1, 2, 1, 1, 1, 1, 1, 0};
  int full_idx  [13] = '{0, 0, 0, 1, 0, 2, 0, 3, 4, 5, 6, 7, 0};

  logic [31:0] fa, la, ea, ed, rfa, rfd, rld;
  logic        lv, fv, rfv, rlv;
  int          k, pk;

  initial begin
    Rst = 1'b1;
    FabReqValid = 1'b1; FabReqOpcode = WR; FabReqAddress = 32'h0000_0040;
    FabReqData = 32'h5555_5555; FabReqRequestorId = 8'h09;
    LocReqValid = 1'b1; LocReqWrEn = 1'b1; LocReqAddress = 32'h0000_0080; LocReqData = 32'h6666_6666;

    // Reset state, with both requesters active.
    @(negedge clk);
    check_eq("rst.frdy", 64'(FabReqReady), 64'd1);
    check_eq("rst.lrdy", 64'(LocReqReady), 64'd0);
    check_eq("rst.wren", 64'(PortBWrEn), 64'd0);
    check_eq("rst.rden", 64'(PortBRdEn), 64'd0);
    check_eq("rst.addr", 64'(PortBAddress), 64'd0);
    check_eq("rst.data", 64'(PortBData), 64'd0);
    check_rsp("rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    Rst = 1'b0; FabReqValid = 1'b0; LocReqValid = 1'b0;

    // Single fabric write.
    cyc("wr_push", 1'b1, WR, 32'h0001_0004, 32'hDEAD_BEEF, 8'h01, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("wr_issue", 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b1, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF);
    idle("wr_empty", 1'b1);
    idle("wr_after", 1'b1);
    check_rsp("wr_norsp", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Fabric read: response at grant+2.
    cyc("rd_push", 1'b1, RD, 32'h0001_0010, 32'h0, 8'h05, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("rd_issue", 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0010, 32'h0);
    idle("rd_n1", 1'b1);
    check_rsp("rd_n1", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle("rd_n2", 1'b1);
    check_rsp("rd_n2", 1'b1, 32'h0501_0010, 32'h1234_5678, 1'b0, 32'h0);
    idle("rd_n3", 1'b1);
    check_rsp("rd_n3", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Local write (only candidate); leaves fabric with priority.
    cyc("loc_wr", 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D,
        1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);

    // Contention: 4 fabric reads vs a stream of local reads -> F,L,F,L,...
    for (int c = 0; c < 10; c++) begin
      fv = (c < 4);
      fa = 32'h0002_0000 + 32'(4 * c);
      lv = (c >= 1 && c <= 6);
      la = 32'h0000_0200 + 32'(4 * ((c - 1) / 2));
      k  = con_idx[c];
      ea = (con_kind[c] == 1) ? 32'h0002_0000 + 32'(4 * k) :
           (con_kind[c] == 2) ? 32'h0000_0200 + 32'(4 * k) : 32'h0;
      cyc($sformatf("con%0d", c), fv, RD, fa, 32'h0, 8'(c + 1), lv, 1'b0, la, 32'h0,
          1'b1, con_kind[c] == 2, 1'b0, con_kind[c] != 0, ea, 32'h0);
      rfv = 1'b0; rlv = 1'b0; rfa = '0; rfd = '0; rld = '0;
      if (c >= 2) begin
        pk  = con_idx[c - 2];
        rfv = (con_kind[c - 2] == 1);
        rlv = (con_kind[c - 2] == 2);
        rfa = {8'(pk + 1), 24'h02_0000 + 24'(4 * pk)};
        rfd = mem_val(32'h0002_0000 + 32'(4 * pk));
        rld = mem_val(32'h0000_0200 + 32'(4 * pk));
      end
      check_rsp($sformatf("con%0d", c), rfv, rfa, rfd, rlv, rld);
    end

    // Full queue: local writer holds every other slot, fabric pushes every cycle.
    for (int c = 0; c < 13; c++) begin
      fv = (c <= 8);
      k  = (c < 7) ? c : 7;
      fa = 32'h0003_0000 + 32'(4 * k);
      lv = (c <= 7);
      pk = full_idx[c];
      ea = (full_kind[c] == 1) ? 32'h0003_0000 + 32'(4 * pk) :
           (full_kind[c] == 2) ? 32'h0000_0300 : 32'h0;
      ed = (full_kind[c] == 1) ? 32'hE000_0000 + 32'(pk) :
           (full_kind[c] == 2) ? 32'h1111_0000 : 32'h0;
      cyc($sformatf("full%0d", c), fv, WR, fa, 32'hE000_0000 + 32'(k), 8'h0,
          lv, 1'b1, 32'h0000_0300, 32'h1111_0000,
          c != 7, full_kind[c] == 2, full_kind[c] != 0, 1'b0, ea, ed);
    end

    // Unsupported opcode: popped silently, next entry follows right after.
    cyc("bad_push", 1'b1, RD_RSP, 32'h0005_0000, 32'h77, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("bad_pop", 1'b1, WR, 32'h0005_0004, 32'h88, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("bad_next", 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b1, 1'b0, 32'h0005_0004, 32'h88);

    // Pointer wrap: 10 push/pop pairs back to back.
    for (int i = 0; i < 11; i++) begin
      cyc($sformatf("wrap%0d", i), i < 10, WR, 32'h0006_0000 + 32'(4 * i),
          32'hA000_0000 + 32'(i), 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b1, 1'b0, i > 0, 1'b0,
          (i > 0) ? 32'h0006_0000 + 32'(4 * (i - 1)) : 32'h0,
          (i > 0) ? 32'hA000_0000 + 32'(i - 1) : 32'h0);
    end

    // Reset the cycle after a read grant: the response is dropped.
    cyc("rr_push", 1'b1, RD, 32'h0004_0000, 32'h0, 8'h07, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("rr_grant", 1'b0, WR, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 1'b1, 32'h0004_0000, 32'h0);
    @(posedge clk); #1;
    Rst = 1'b1;
    FabReqValid = 1'b1; FabReqOpcode = WR; FabReqAddress = 32'h0007_0000;
    LocReqValid = 1'b1; LocReqWrEn = 1'b0; LocReqAddress = 32'h0000_0400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rr_in.frdy", 64'(FabReqReady), 64'd1);
      check_eq("rr_in.lrdy", 64'(LocReqReady), 64'd0);
      check_eq("rr_in.wren", 64'(PortBWrEn), 64'd0);
      check_eq("rr_in.rden", 64'(PortBRdEn), 64'd0);
      check_eq("rr_in.addr", 64'(PortBAddress), 64'd0);
      check_rsp("rr_in", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
    end
    Rst = 1'b0; FabReqValid = 1'b0; LocReqValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rr_out.frdy", 64'(FabReqReady), 64'd1);
      check_eq("rr_out.wren", 64'(PortBWrEn), 64'd0);
      check_eq("rr_out.rden", 64'(PortBRdEn), 64'd0);
      check_rsp("rr_out", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
    end

    // Exactly the expected response pulses over the whole run.
    check_eq("fab_rsp_total", 64'(fab_rsp_seen), 64'd5);
    check_eq("loc_rsp_total", 64'(loc_rsp_seen), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
